// File: rtl/eth_tx_framer_pkg.sv
// Shared definitions for the Ethernet transmit framer: FSM encoding, framing
// byte constants and the reflected CRC-32 byte update.
package eth_tx_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_SFD, ST_DATA, ST_PAD, ST_FCS, ST_IPG, ST_DROP
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [7:0]  PAD_BYTE      = 8'h00;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  // Register value left after a frame plus its own FCS has been shifted in.
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_tx_framer_crc.sv
// Byte-wide Ethernet CRC-32 (LSB-first); crc_out is the complemented register,
// whose low byte is transmitted first.
module eth_crc
  import eth_tx_framer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_in,
  input  logic [7:0]  d_in,
  output logic [31:0] crc_out,
  output logic        crc_ok
);

  logic [31:0] crc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 32'hFFFFFFFF;
    end else if (en_in) begin
      crc_q <= crc32_byte(crc_q, d_in);
    end
  end

  assign crc_out = ~crc_q;
  assign crc_ok  = (crc_q == CRC_RESIDUE);

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: preamble/SFD, payload pass-through, zero padding,
// FCS append, inter-packet gap and underrun drop handling.
module eth_tx_framer
  import eth_tx_framer_pkg::*;
#(
  parameter int PRE_LEN = 7,
  parameter int MIN_LEN = 60,
  parameter int IPG_LEN = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_en,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       underrun
);

  localparam logic [15:0] PRE_END  = 16'(PRE_LEN);
  localparam logic [15:0] MIN_CNT  = 16'(MIN_LEN);
  localparam logic [15:0] IPG_LAST = 16'(IPG_LEN - 1);

  state_t      state;
  logic [15:0] pre_cnt;
  logic [15:0] ipg_cnt;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic [31:0] fcs_reg;
  logic [2:0]  fcs_idx;
  logic        crc_init;
  logic        crc_rst;
  logic        accept;
  logic        start;
  logic        feed_en;
  logic [7:0]  feed_byte;
  logic [31:0] crc_out;

  // Feed strobe is combinational so the CRC advances on the same edge that
  // loads the byte onto out_data; the FCS then sees the final byte at once.
  always_comb begin
    accept    = in_valid && in_ready;
    cnt_inc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    start     = in_valid && ((state == ST_IDLE) || (state == ST_IPG && ipg_cnt == IPG_LAST));
    feed_en   = 1'b0;
    feed_byte = PAD_BYTE;
    if ((state == ST_SFD || state == ST_DATA) && accept) begin
      feed_en   = 1'b1;
      feed_byte = in_data;
    end else if (state == ST_PAD) begin
      feed_en = 1'b1;
    end
  end

  assign crc_rst = rst | crc_init;

  eth_crc u_crc (
    .clk    (clk),
    .rst    (crc_rst),
    .en_in  (feed_en),
    .d_in   (feed_byte),
    .crc_out(crc_out),
    .crc_ok ()
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      out_en   <= 1'b0;
      out_data <= 8'h00;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
      cnt      <= 16'd0;
      fcs_reg  <= 32'd0;
      fcs_idx  <= 3'd0;
      pre_cnt  <= 16'd0;
      ipg_cnt  <= 16'd0;
      crc_init <= 1'b0;
    end else begin
      underrun <= 1'b0;
      // The last gap cycle doubles as the first idle cycle so back-to-back
      // frames are separated by exactly IPG_LEN dead cycles.
      if (start) begin
        state    <= ST_PRE;
        out_en   <= 1'b1;
        out_data <= PREAMBLE_BYTE;
        busy     <= 1'b1;
        cnt      <= 16'd0;
        pre_cnt  <= 16'd1;
        fcs_idx  <= 3'd0;
        crc_init <= 1'b1;
      end else begin
        case (state)
          ST_PRE: begin
            if (pre_cnt == PRE_END) begin
              state    <= ST_SFD;
              out_data <= SFD_BYTE;
              in_ready <= 1'b1;
              crc_init <= 1'b0;
            end else begin
              pre_cnt <= pre_cnt + 16'd1;
            end
          end
          ST_SFD, ST_DATA: begin
            if (accept) begin
              out_data <= in_data;
              cnt      <= cnt_inc;
              if (in_last) begin
                in_ready <= 1'b0;
                state    <= (cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
              end else begin
                state <= ST_DATA;
              end
            end else begin
              underrun <= 1'b1;
              out_en   <= 1'b0;
              out_data <= 8'h00;
              state    <= ST_DROP;
            end
          end
          ST_PAD: begin
            out_data <= PAD_BYTE;
            cnt      <= cnt_inc;
            if (cnt_inc >= MIN_CNT) state <= ST_FCS;
          end
          ST_FCS: begin
            fcs_idx <= fcs_idx + 3'd1;
            case (fcs_idx)
              3'd0: begin
                out_data <= crc_out[7:0];
                fcs_reg  <= crc_out;
              end
              3'd1: out_data <= fcs_reg[15:8];
              3'd2: out_data <= fcs_reg[23:16];
              3'd3: out_data <= fcs_reg[31:24];
              default: begin
                out_en   <= 1'b0;
                out_data <= 8'h00;
                ipg_cnt  <= 16'd0;
                state    <= ST_IPG;
              end
            endcase
          end
          ST_IPG: begin
            if (ipg_cnt == IPG_LAST) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              ipg_cnt <= ipg_cnt + 16'd1;
            end
          end
          ST_DROP: begin
            if (accept && in_last) begin
              in_ready <= 1'b0;
              ipg_cnt  <= 16'd0;
              state    <= ST_IPG;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: one MIN_LEN=0 instance, one default
// instance, and an independent eth_crc used to check transmitted FCS fields.
module tb_eth_tx_framer;

  typedef struct packed {
    logic       busy;
    logic       dk;
    logic       en;
    logic [7:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_last, sel;
  logic [7:0] in_data;
  logic       v0, v1;
  logic       rdy0, en0, busy0, und0, rdy1, en1, busy1, und1;
  logic [7:0] data0, data1;
  logic       rdy, en, bsy, und;
  logic [7:0] dat;
  logic       chk_rst, chk_en, chk_ok;
  logic [7:0] chk_d;
  logic [31:0] chk_crc;

  int tests, fails;
  logic [7:0] pl [0:127];
  logic [7:0] dlog[$];
  bit elog[$], blog[$], ulog[$], rlog[$];

  always #5 clk = ~clk;

  assign v0  = in_valid & ~sel;
  assign v1  = in_valid & sel;
  assign rdy = sel ? rdy1 : rdy0;
  assign en  = sel ? en1 : en0;
  assign bsy = sel ? busy1 : busy0;
  assign und = sel ? und1 : und0;
  assign dat = sel ? data1 : data0;

  eth_tx_framer #(.MIN_LEN(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy0), .out_en(en0), .out_data(data0), .busy(busy0), .underrun(und0)
  );

  eth_tx_framer dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy1), .out_en(en1), .out_data(data1), .busy(busy1), .underrun(und1)
  );

  eth_crc chk (
    .clk(clk), .rst(chk_rst), .en_in(chk_en), .d_in(chk_d),
    .crc_out(chk_crc), .crc_ok(chk_ok)
  );

  // Expected per-cycle view of a frame whose start request is seen at cycle 0.
  function automatic exp_t exp_frame(int c, int npay, int npad);
    exp_t e;
    int s;
    s = 8 + npay + npad;
    e = '{busy: 1'b0, dk: 1'b1, en: 1'b0, d: 8'h00};
    if (c >= 1 && c <= s + 16) e.busy = 1'b1;
    if (c >= 1 && c <= 7) begin e.en = 1'b1; e.d = 8'h55; end
    else if (c == 8) begin e.en = 1'b1; e.d = 8'hD5; end
    else if (c >= 9 && c <= 8 + npay) begin e.en = 1'b1; e.d = pl[c-9]; end
    else if (c > 8 + npay && c <= s) begin e.en = 1'b1; e.d = 8'h00; end
    else if (c > s && c <= s + 4) begin e.en = 1'b1; e.dk = 1'b0; end
    return e;
  endfunction

  task automatic run(input int nbytes, input int frames, input int hole_at, input int cycles);
    int idx;
    bit pv, pr, hole_done;
    dlog.delete(); elog.delete(); blog.delete(); ulog.delete(); rlog.delete();
    idx = 0; pv = 0; pr = 0; hole_done = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (pv && pr) idx++;
      dlog.push_back(dat); elog.push_back(en); blog.push_back(bsy);
      ulog.push_back(und); rlog.push_back(rdy);
      if (idx < nbytes * frames && !(idx == hole_at && !hole_done)) begin
        in_valid = 1'b1;
        in_data  = pl[idx % nbytes];
        in_last  = (idx % nbytes == nbytes - 1);
      end else begin
        if (idx == hole_at) hole_done = 1;
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
      end
      pv = in_valid; pr = rdy;
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
  endtask

  task automatic crc_feed(input int a, input int b);
    chk_rst = 1'b1; #1; chk_rst = 1'b0;
    for (int i = a; i <= b; i++) begin
      chk_en = 1'b1; chk_d = dlog[i];
      @(posedge clk); #1;
    end
    chk_en = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      tests++; if (en !== 1'b0) begin fails++; $display("[TB] FAIL reset_en dut%0d got %b want 0", s, en); end
      tests++; if (dat !== 8'h00) begin fails++; $display("[TB] FAIL reset_data dut%0d got %h want 00", s, dat); end
      tests++; if (rdy !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready dut%0d got %b want 0", s, rdy); end
      tests++; if (bsy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy dut%0d got %b want 0", s, bsy); end
      tests++; if (und !== 1'b0) begin fails++; $display("[TB] FAIL reset_underrun dut%0d got %b want 0", s, und); end
    end
    rst = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_min0;
    exp_t e;
    logic [7:0] fcs [0:3];
    fcs[0] = 8'h26; fcs[1] = 8'h39; fcs[2] = 8'hF4; fcs[3] = 8'hCB;
    sel = 1'b0;
    for (int i = 0; i < 9; i++) pl[i] = 8'(8'h31 + i);
    run(9, 1, -1, 40);
    for (int c = 0; c < 40; c++) begin
      e = exp_frame(c, 9, 0);
      if (c >= 18 && c <= 21) begin e.dk = 1'b1; e.d = fcs[c-18]; end
      tests++; if (elog[c] !== e.en) begin fails++; $display("[TB] FAIL min0_en c=%0d got %b want %b", c, elog[c], e.en); end
      tests++; if (dlog[c] !== e.d) begin fails++; $display("[TB] FAIL min0_data c=%0d got %h want %h", c, dlog[c], e.d); end
      tests++; if (blog[c] !== e.busy) begin fails++; $display("[TB] FAIL min0_busy c=%0d got %b want %b", c, blog[c], e.busy); end
      tests++; if (rlog[c] !== (c >= 8 && c <= 16)) begin fails++; $display("[TB] FAIL min0_ready c=%0d got %b", c, rlog[c]); end
      tests++; if (ulog[c] !== 1'b0) begin fails++; $display("[TB] FAIL min0_underrun c=%0d got %b want 0", c, ulog[c]); end
    end
  endtask

  task automatic test_pad;
    exp_t e;
    sel = 1'b1;
    for (int i = 0; i < 14; i++) pl[i] = 8'(8'hA0 + i);
    run(14, 1, -1, 90);
    for (int c = 0; c < 90; c++) begin
      e = exp_frame(c, 14, 46);
      tests++; if (elog[c] !== e.en) begin fails++; $display("[TB] FAIL pad_en c=%0d got %b want %b", c, elog[c], e.en); end
      tests++; if (blog[c] !== e.busy) begin fails++; $display("[TB] FAIL pad_busy c=%0d got %b want %b", c, blog[c], e.busy); end
      if (e.dk) begin
        tests++; if (dlog[c] !== e.d) begin fails++; $display("[TB] FAIL pad_data c=%0d got %h want %h", c, dlog[c], e.d); end
      end
    end
    crc_feed(9, 72);
    tests++; if (chk_ok !== 1'b1) begin fails++; $display("[TB] FAIL pad_crc_ok got %b want 1", chk_ok); end
  endtask

  task automatic test_exact60;
    exp_t e;
    int n_en;
    sel = 1'b1;
    for (int i = 0; i < 60; i++) pl[i] = 8'(i + 1);
    run(60, 1, -1, 90);
    n_en = 0;
    for (int c = 0; c < 90; c++) begin
      e = exp_frame(c, 60, 0);
      if (elog[c]) n_en++;
      tests++; if (elog[c] !== e.en) begin fails++; $display("[TB] FAIL exact60_en c=%0d got %b want %b", c, elog[c], e.en); end
      if (e.dk) begin
        tests++; if (dlog[c] !== e.d) begin fails++; $display("[TB] FAIL exact60_data c=%0d got %h want %h", c, dlog[c], e.d); end
      end
    end
    tests++; if (n_en !== 72) begin fails++; $display("[TB] FAIL exact60_en_count got %0d want 72", n_en); end
    crc_feed(9, 72);
    tests++; if (chk_ok !== 1'b1) begin fails++; $display("[TB] FAIL exact60_crc_ok got %b want 1", chk_ok); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int gap;
    sel = 1'b1;
    for (int i = 0; i < 64; i++) pl[i] = 8'(8'h80 ^ i);
    run(64, 2, -1, 185);
    for (int c = 0; c < 185; c++) begin
      e = (c <= 88) ? exp_frame(c, 64, 0) : exp_frame(c - 88, 64, 0);
      tests++; if (elog[c] !== e.en) begin fails++; $display("[TB] FAIL b2b_en c=%0d got %b want %b", c, elog[c], e.en); end
      tests++; if (blog[c] !== e.busy) begin fails++; $display("[TB] FAIL b2b_busy c=%0d got %b want %b", c, blog[c], e.busy); end
      if (e.dk) begin
        tests++; if (dlog[c] !== e.d) begin fails++; $display("[TB] FAIL b2b_data c=%0d got %h want %h", c, dlog[c], e.d); end
      end
    end
    gap = 0;
    for (int c = 77; c < 120 && !elog[c]; c++) gap++;
    tests++; if (gap !== 12) begin fails++; $display("[TB] FAIL b2b_gap got %0d want 12", gap); end
    crc_feed(9, 76);
    tests++; if (chk_ok !== 1'b1) begin fails++; $display("[TB] FAIL b2b_crc_ok1 got %b want 1", chk_ok); end
    crc_feed(97, 164);
    tests++; if (chk_ok !== 1'b1) begin fails++; $display("[TB] FAIL b2b_crc_ok2 got %b want 1", chk_ok); end
  endtask

  task automatic test_underrun;
    exp_t e;
    int n_und, n_en;
    sel = 1'b1;
    for (int i = 0; i < 64; i++) pl[i] = 8'(i + 1);
    run(64, 1, 20, 100);
    for (int c = 0; c <= 28; c++) begin
      e = exp_frame(c, 64, 0);
      tests++; if ({elog[c], dlog[c]} !== {e.en, e.d}) begin fails++; $display("[TB] FAIL urun_head c=%0d got %b/%h want %b/%h", c, elog[c], dlog[c], e.en, e.d); end
    end
    n_und = 0; n_en = 0;
    for (int c = 0; c < 100; c++) begin
      if (ulog[c]) n_und++;
      if (c >= 29 && elog[c]) n_en++;
    end
    tests++; if (ulog[29] !== 1'b1) begin fails++; $display("[TB] FAIL urun_pulse got %b want 1", ulog[29]); end
    tests++; if (n_und !== 1) begin fails++; $display("[TB] FAIL urun_pulse_count got %0d want 1", n_und); end
    tests++; if (n_en !== 0) begin fails++; $display("[TB] FAIL urun_en_after got %0d want 0", n_en); end
    tests++; if (dlog[29] !== 8'h00) begin fails++; $display("[TB] FAIL urun_data got %h want 00", dlog[29]); end
    tests++; if (rlog[29] !== 1'b1) begin fails++; $display("[TB] FAIL urun_drop_ready got %b want 1", rlog[29]); end
    tests++; if (rlog[72] !== 1'b1) begin fails++; $display("[TB] FAIL urun_ready_last got %b want 1", rlog[72]); end
    tests++; if (rlog[73] !== 1'b0) begin fails++; $display("[TB] FAIL urun_ready_after got %b want 0", rlog[73]); end
    tests++; if (blog[84] !== 1'b1) begin fails++; $display("[TB] FAIL urun_busy_ipg got %b want 1", blog[84]); end
    tests++; if (blog[85] !== 1'b0) begin fails++; $display("[TB] FAIL urun_busy_end got %b want 0", blog[85]); end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    logic [7:0] fcs [0:3];
    fcs[0] = 8'h26; fcs[1] = 8'h39; fcs[2] = 8'hF4; fcs[3] = 8'hCB;
    sel = 1'b0;
    for (int i = 0; i < 9; i++) pl[i] = 8'(8'h31 + i);
    run(9, 1, -1, 20);
    tests++; if ({elog[19], dlog[19]} !== {1'b1, 8'h39}) begin fails++; $display("[TB] FAIL rmid_before got %b/%h want 1/39", elog[19], dlog[19]); end
    rst = 1'b1; #1;
    tests++; if (en !== 1'b0) begin fails++; $display("[TB] FAIL rmid_en got %b want 0", en); end
    tests++; if (dat !== 8'h00) begin fails++; $display("[TB] FAIL rmid_data got %h want 00", dat); end
    tests++; if (bsy !== 1'b0) begin fails++; $display("[TB] FAIL rmid_busy got %b want 0", bsy); end
    tests++; if (rdy !== 1'b0) begin fails++; $display("[TB] FAIL rmid_ready got %b want 0", rdy); end
    tests++; if (und !== 1'b0) begin fails++; $display("[TB] FAIL rmid_underrun got %b want 0", und); end
    #1; rst = 1'b0;
    repeat (3) @(posedge clk);
    run(9, 1, -1, 36);
    for (int c = 0; c < 36; c++) begin
      e = exp_frame(c, 9, 0);
      if (c >= 18 && c <= 21) begin e.dk = 1'b1; e.d = fcs[c-18]; end
      tests++; if ({elog[c], dlog[c], blog[c]} !== {e.en, e.d, e.busy}) begin
        fails++; $display("[TB] FAIL rmid_after c=%0d got %b/%h/%b want %b/%h/%b", c, elog[c], dlog[c], blog[c], e.en, e.d, e.busy);
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; sel = 1'b0;
    chk_rst = 1'b1; chk_en = 1'b0; chk_d = 8'h00;
    test_reset;
    test_min0;
    test_pad;
    test_exact60;
    test_back_to_back;
    test_underrun;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
